// File: rtl/frame_pos_buffer_if.sv
// Bundle of the producer, reader and status signals of frame_pos_buffer.
// The buffer takes the slave view; the producer/reader side takes the master view.
interface frame_pos_buffer_if #(
    parameter int POS_W      = 16,
    parameter int GRAY_W     = 16,
    parameter int DEPTH_LOG2 = 11
);
    logic                    update_enable;
    logic                    cycle_enable;
    logic                    target_valid;
    logic [POS_W-1:0]        target_pos;
    logic [GRAY_W-1:0]       target_gray;
    logic                    rd_ready;
    logic                    rd_valid;
    logic [GRAY_W+POS_W-1:0] rd_data;
    logic                    rd_sof;
    logic                    rd_eof;
    logic [DEPTH_LOG2:0]     used_words;
    logic [15:0]             drop_cnt;
    logic                    flush_pulse;

    modport master (
        output update_enable, cycle_enable, target_valid, target_pos, target_gray, rd_ready,
        input  rd_valid, rd_data, rd_sof, rd_eof, used_words, drop_cnt, flush_pulse
    );

    modport slave (
        input  update_enable, cycle_enable, target_valid, target_pos, target_gray, rd_ready,
        output rd_valid, rd_data, rd_sof, rd_eof, used_words, drop_cnt, flush_pulse
    );
endinterface

// File: rtl/frame_pos_buffer.sv
// Frame buffer for one scan cycle of {gray, pos} samples.
// A frame is admitted only if it fits entirely, and becomes visible to the reader
// only when it ends with exactly FRAME_LEN samples; anything else is rolled back.
// The read side is first-word-fall-through: a RAM read stage feeds an output register.
// A reader that stalls for TIMEOUT_CYC cycles gets all committed words flushed.
module frame_pos_buffer #(
    parameter int POS_W       = 16,
    parameter int GRAY_W      = 16,
    parameter int DEPTH_LOG2  = 11,
    parameter int FRAME_LEN   = 811,
    parameter int TIMEOUT_CYC = 10_000_000
) (
    input  logic             clk,
    input  logic             rst,
    frame_pos_buffer_if.slave bus
);
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int DW    = GRAY_W + POS_W;
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = $clog2(FRAME_LEN + 1);
    localparam int SW    = $clog2(TIMEOUT_CYC + 1);

    localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
    localparam logic [PW-1:0] FLEN_P   = PW'(FRAME_LEN);
    localparam logic [CW-1:0] FLEN_C   = CW'(FRAME_LEN);
    localparam logic [CW-1:0] FLAST_C  = CW'(FRAME_LEN - 1);
    localparam logic [SW-1:0] TO_LAST  = SW'(TIMEOUT_CYC - 1);

    // Storage
    logic [DW-1:0]         r_mem [DEPTH];
    logic [DW-1:0]         r_s1_data;

    // Write side state
    logic [1:0]            r_ce;
    logic                  r_active;
    logic                  r_overrun;
    logic [CW-1:0]         r_smp_cnt;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_wr_commit;
    logic [15:0]           r_drop_cnt;

    // Read side state
    logic [PW-1:0]         r_rd_ptr;     // oldest word still in RAM or the read stage
    logic                  r_s1_valid;
    logic                  r_out_valid;
    logic [DW-1:0]         r_rd_data;
    logic [CW-1:0]         r_rd_idx;     // position of the output word within its frame
    logic [SW-1:0]         r_stall_cnt;
    logic                  r_flush;

    logic                  w_rise, w_fall;
    logic [PW-1:0]         w_free;
    logic                  w_admit, w_cap, w_wr_en;
    logic [DEPTH_LOG2-1:0] w_wr_addr, w_fetch_addr;
    logic                  w_xfer, w_s1_move, w_fetch;
    logic [PW-1:0]         w_avail, w_used;
    logic                  w_stall, w_timeout;

    assign w_rise    = (r_ce == 2'b01);
    assign w_fall    = (r_ce == 2'b10);
    assign w_free    = DEPTH_P - (r_wr_ptr - r_rd_ptr);
    assign w_admit   = w_rise & bus.update_enable & (w_free >= FLEN_P);
    assign w_cap     = r_active & bus.target_valid & ~w_fall;
    assign w_wr_en   = w_cap & (r_smp_cnt < FLEN_C);
    assign w_wr_addr = r_wr_ptr[DEPTH_LOG2-1:0];

    // The read stage holds the word at r_rd_ptr, so the next fetch skips past it.
    assign w_xfer       = r_out_valid & bus.rd_ready;
    assign w_s1_move    = r_s1_valid & (~r_out_valid | w_xfer);
    assign w_avail      = r_wr_commit - r_rd_ptr - PW'(r_s1_valid);
    assign w_fetch      = (w_avail != '0) & (~r_s1_valid | w_s1_move);
    assign w_fetch_addr = r_rd_ptr[DEPTH_LOG2-1:0] + DEPTH_LOG2'(r_s1_valid);

    assign w_used    = r_wr_commit - r_rd_ptr + PW'(r_out_valid);
    assign w_stall   = bus.update_enable & (w_used != '0) & ~w_xfer;
    assign w_timeout = w_stall & (r_stall_cnt == TO_LAST);

    // Sample RAM write port and read stage data
    // NOTE: RAM contents and the read-stage data are not reset; validity is tracked by the reset flags.
    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[w_wr_addr] <= {bus.target_gray, bus.target_pos};
        if (w_fetch)
            r_s1_data <= r_mem[w_fetch_addr];
    end

    // Frame admission, capture, and commit or rollback at cycle end
    // NOTE: all clocked state uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ce        <= 2'b00;
            r_active    <= 1'b0;
            r_overrun   <= 1'b0;
            r_smp_cnt   <= '0;
            r_wr_ptr    <= '0;
            r_wr_commit <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_ce <= {r_ce[0], bus.cycle_enable};
            if (w_admit) begin
                r_active  <= 1'b1;
                r_overrun <= 1'b0;
                r_smp_cnt <= '0;
            end else if (r_active && w_fall) begin
                r_active <= 1'b0;
                if (r_smp_cnt == FLEN_C && !r_overrun) begin
                    r_wr_commit <= r_wr_ptr;
                end else begin
                    r_wr_ptr <= r_wr_commit;
                    if (r_drop_cnt != 16'hFFFF)
                        r_drop_cnt <= r_drop_cnt + 16'd1;
                end
            end else if (w_cap) begin
                if (w_wr_en) begin
                    r_wr_ptr  <= r_wr_ptr + PW'(1);
                    r_smp_cnt <= r_smp_cnt + CW'(1);
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    // Read pipeline, frame word index and stall-timeout flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr    <= '0;
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_rd_data   <= '0;
            r_rd_idx    <= '0;
            r_stall_cnt <= '0;
            r_flush     <= 1'b0;
        end else begin
            r_flush <= w_timeout;
            if (w_timeout) begin
                // Drop everything committed so far; a frame committing this edge survives.
                r_rd_ptr    <= r_wr_commit;
                r_s1_valid  <= 1'b0;
                r_out_valid <= 1'b0;
                r_rd_idx    <= '0;
                r_stall_cnt <= '0;
            end else begin
                r_stall_cnt <= w_stall ? r_stall_cnt + SW'(1) : '0;
                if (w_s1_move) begin
                    r_out_valid <= 1'b1;
                    r_rd_data   <= r_s1_data;
                    r_rd_ptr    <= r_rd_ptr + PW'(1);
                end else if (w_xfer) begin
                    r_out_valid <= 1'b0;
                end
                if (w_fetch)
                    r_s1_valid <= 1'b1;
                else if (w_s1_move)
                    r_s1_valid <= 1'b0;
                if (w_xfer)
                    r_rd_idx <= (r_rd_idx == FLAST_C) ? '0 : r_rd_idx + CW'(1);
            end
        end
    end

    assign bus.rd_valid    = r_out_valid;
    assign bus.rd_data     = r_rd_data;
    assign bus.rd_sof      = r_out_valid & (r_rd_idx == '0);
    assign bus.rd_eof      = r_out_valid & (r_rd_idx == FLAST_C);
    assign bus.used_words  = w_used;
    assign bus.drop_cnt    = r_drop_cnt;
    assign bus.flush_pulse = r_flush;
endmodule

// File: tb/tb_frame_pos_buffer.sv
// Self-checking bench for frame_pos_buffer with FRAME_LEN=4, DEPTH_LOG2=4, TIMEOUT_CYC=50.
// Expected words (with sof/eof) are queued when a good frame is driven and popped
// by a monitor whenever the DUT transfers a word.
module tb_frame_pos_buffer;
    localparam int FL = 4;
    localparam int DL = 4;
    localparam int TO = 50;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    frame_pos_buffer_if #(.POS_W(16), .GRAY_W(16), .DEPTH_LOG2(DL)) bus ();

    frame_pos_buffer #(
        .POS_W(16), .GRAY_W(16), .DEPTH_LOG2(DL), .FRAME_LEN(FL), .TIMEOUT_CYC(TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int exp_drop = 0;
    logic [33:0] sb[$];   // {sof, eof, gray, pos}

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Rise of cycle_enable; admission is decided two edges later.
    task automatic start_frame(input bit drop_ue);
        bus.update_enable = 1'b1;
        bus.cycle_enable  = 1'b1;
        tick();
        tick();
        if (drop_ue) bus.update_enable = 1'b0;
    endtask

    task automatic put_samples(input int n, input int base, input int first);
        for (int i = 0; i < n; i++) begin
            bus.target_valid = 1'b1;
            bus.target_pos   = 16'(base + first + i + 1);
            bus.target_gray  = 16'(16'h000A + base + first + i);
            tick();
        end
        bus.target_valid = 1'b0;
    endtask

    task automatic push_frame(input int base);
        for (int i = 0; i < FL; i++)
            sb.push_back({(i == 0), (i == FL - 1), 16'(16'h000A + base + i), 16'(base + i + 1)});
    endtask

    task automatic end_frame();
        bus.cycle_enable = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic good_frame(input int base, input bit drop_ue);
        start_frame(drop_ue);
        put_samples(FL, base, 0);
        push_frame(base);
        end_frame();
    endtask

    task automatic drain(input string tag);
        bit done = 1'b0;
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            if (sb.size() == 0 && !bus.rd_valid) done = 1'b1;
        end
        check({tag, "_drained"}, done, 1'b1);
        check({tag, "_used_zero"}, bus.used_words, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd_valid"}, bus.rd_valid, 0);
        check({tag, "_rd_data"},  bus.rd_data, 0);
        check({tag, "_sof_eof"},  {bus.rd_sof, bus.rd_eof}, 0);
        check({tag, "_used"},     bus.used_words, 0);
        check({tag, "_drop"},     bus.drop_cnt, 0);
        check({tag, "_flush"},    bus.flush_pulse, 0);
    endtask

    // Scoreboard monitor: a word transfers on the next rising edge.
    always @(negedge clk) begin
        if (rst && bus.rd_valid && bus.rd_ready) begin
            check("sb_has_entry", (sb.size() != 0), 1'b1);
            if (sb.size() != 0)
                check("rd_word", {bus.rd_sof, bus.rd_eof, bus.rd_data}, sb.pop_front());
        end
    end

    // Watchdog against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        bus.update_enable = 1'b0;
        bus.cycle_enable  = 1'b0;
        bus.target_valid  = 1'b0;
        bus.target_pos    = '0;
        bus.target_gray   = '0;
        bus.rd_ready      = 1'b0;
        tick();
        check_idle_outputs("in_reset");
        rst = 1'b1;
        tick();
        tick();
        check_idle_outputs("after_reset");

        // 1. Nominal frame: hold the reader off briefly to observe used_words = 4.
        good_frame(16'h0000, 1'b0);
        tick();
        tick();
        check("t1_used_full", bus.used_words, 4);
        check("t1_valid", bus.rd_valid, 1);
        check("t1_sof_first", bus.rd_sof, 1);
        drain("t1");

        // 2. Short frame is rolled back, then a good frame reads out.
        start_frame(1'b0);
        put_samples(3, 16'h0100, 0);
        end_frame();
        exp_drop++;
        tick();
        tick();
        check("t2_no_valid", bus.rd_valid, 0);
        check("t2_drop", bus.drop_cnt, exp_drop);
        check("t2_used", bus.used_words, 0);
        good_frame(16'h0200, 1'b0);
        drain("t2");

        // 3. Overrun: five samples in one cycle, then a good frame at the restored pointer.
        start_frame(1'b0);
        put_samples(5, 16'h0300, 0);
        end_frame();
        exp_drop++;
        tick();
        tick();
        check("t3_no_valid", bus.rd_valid, 0);
        check("t3_drop", bus.drop_cnt, exp_drop);
        check("t3_used", bus.used_words, 0);
        good_frame(16'h0400, 1'b0);
        drain("t3");

        // 4. Full: four frames fill the buffer; the fifth is refused silently.
        //    update_enable drops after each admission so the stalled reader never times out.
        bus.rd_ready = 1'b0;
        for (int f = 0; f < 4; f++)
            good_frame(16'h0500 + 16'h10 * f, 1'b1);
        tick();
        tick();
        check("t4_used_16", bus.used_words, 16);
        start_frame(1'b1);
        put_samples(FL, 16'h0600, 0);
        end_frame();
        tick();
        check("t4_used_still_16", bus.used_words, 16);
        check("t4_drop_unchanged", bus.drop_cnt, exp_drop);
        check("t4_head_sof", bus.rd_sof, 1);
        bus.update_enable = 1'b1;
        drain("t4");

        // 5. Timeout flush with a frame in flight across the flush.
        bus.rd_ready = 1'b0;
        good_frame(16'h0700, 1'b0);
        for (int i = 0; i < 32; i++) tick();
        start_frame(1'b0);
        put_samples(2, 16'h0800, 0);
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            tick();
            if (bus.flush_pulse) seen = 1'b1;
        end
        check("t5_flush_seen", seen, 1'b1);
        check("t5_used_after_flush", bus.used_words, 0);
        check("t5_valid_after_flush", bus.rd_valid, 0);
        sb.delete();
        tick();
        check("t5_flush_one_cycle", bus.flush_pulse, 0);
        put_samples(2, 16'h0800, 2);
        push_frame(16'h0800);
        end_frame();
        tick();
        tick();
        check("t5_inflight_used", bus.used_words, 4);
        check("t5_drop_unchanged", bus.drop_cnt, exp_drop);
        drain("t5");

        // 6. Reset in the middle of a frame, then a clean frame.
        start_frame(1'b0);
        put_samples(2, 16'h0900, 0);
        rst = 1'b0;
        #1;
        check_idle_outputs("t6_in_reset");
        bus.cycle_enable = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        exp_drop = 0;
        tick();
        check_idle_outputs("t6_after_reset");
        good_frame(16'h0A00, 1'b0);
        drain("t6");
        check("t6_drop", bus.drop_cnt, exp_drop);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
